// File: rtl/clock_pkg.sv
// Shared constants for time-of-day counter stages: mode codes and stage sizes.
// Latency: none, constants and a pure decode function only.
// Backpressure: not applicable.
package clock_pkg;

  // Mode codes carried on the 3-bit hold input
  localparam logic [2:0] HOLD_RUN        = 3'b000;
  localparam logic [2:0] HOLD_CLEAR_MASK = 3'b001;
  localparam logic [2:0] HOLD_ADJ        = 3'b010;

  // Default stage geometries for a 24-hour clock
  localparam int SEC_WIDTH   = 6;
  localparam int SEC_MODULUS = 60;
  localparam int MIN_WIDTH   = 6;
  localparam int MIN_MODULUS = 60;
  localparam int HR_WIDTH    = 5;
  localparam int HR_MODULUS  = 24;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_CLEAR  = 2'd1,
    MODE_ADJUST = 2'd2
  } mode_e;

  // Clear wins over adjust whenever bit0 is set; any other nonzero code adjusts
  function automatic mode_e decode_mode(input logic [2:0] hold);
    mode_e m;
    m = MODE_RUN;
    if ((hold & HOLD_CLEAR_MASK) != 3'b000) begin
      m = MODE_CLEAR;
    end else if (hold != HOLD_RUN) begin
      m = MODE_ADJUST;
    end
    return m;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector against a registered copy of the input.
// Latency: pulse is combinational in the cycle the input first reads high.
// Backpressure: none; the history register updates every cycle.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);

  logic in_q;
  logic in_d;

  // History always follows the input, regardless of what the consumer is doing
  always_comb begin
    in_d = in;
  end

  // History register, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in_d;
    end
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/mod_counter.sv
// Cascadable modulo-N up/down counter with clear, load and button adjust.
// Latency: one clk from any qualifying input to count/carry_out.
// Backpressure: none; tick & carry_in act as the count enable.
module mod_counter
  import clock_pkg::*;
#(
  parameter int WIDTH   = 6,
  parameter int MODULUS = 60
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             carry_in,
  input  logic             down,
  input  logic [2:0]       hold,
  input  logic             adj,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry_out
);

  // One extra bit so MODULUS itself and count+1 are representable when MODULUS = 2**WIDTH
  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] ONE_W = (WIDTH+1)'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             adj_pulse;
  mode_e            mode;
  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   lv_ext;
  logic [WIDTH:0]   step_val;
  logic             step_wrap;

  edge_detect u_adj_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (adj),
    .pulse (adj_pulse)
  );

  // Decode the hold code into an operating mode
  always_comb begin
    mode = decode_mode(hold);
  end

  // One step in the current direction, wrapping inside 0..MODULUS-1
  always_comb begin
    cnt_ext   = {1'b0, count_q};
    step_val  = cnt_ext;
    step_wrap = 1'b0;
    if (down) begin
      if (cnt_ext == '0) begin
        step_val  = MOD_W - ONE_W;
        step_wrap = 1'b1;
      end else begin
        step_val  = cnt_ext - ONE_W;
      end
    end else begin
      if (cnt_ext + ONE_W >= MOD_W) begin
        step_val  = '0;
        step_wrap = 1'b1;
      end else begin
        step_val  = cnt_ext + ONE_W;
      end
    end
  end

  // Next-state selection: clear > load > adjust > run; carry only on a run-mode wrap
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    lv_ext  = {1'b0, load_val};
    if (mode == MODE_CLEAR) begin
      count_d = '0;
    end else if (load) begin
      count_d = (lv_ext < MOD_W) ? load_val : '0;
    end else if (mode == MODE_ADJUST) begin
      if (adj_pulse) begin
        count_d = step_val[WIDTH-1:0];
      end
    end else if (tick && carry_in) begin
      count_d = step_val[WIDTH-1:0];
      carry_d = step_wrap;
    end
  end

  // State registers; reset overrides every mode and aborts any pending carry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  assign count     = count_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: directed corner cases, random run, 24h cascade.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_mod_counter;
  import clock_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       carry_in;
  logic       down;
  logic [2:0] hold;
  logic       adj;
  logic       load;
  logic [5:0] load_val;
  logic [5:0] count_a;
  logic       carry_a;
  logic [3:0] count_b;
  logic       carry_b;

  logic       c_tick;
  logic [5:0] sec_cnt;
  logic       sec_co;
  logic [5:0] min_cnt;
  logic       min_co;
  logic [4:0] hr_cnt;
  logic       hr_co;

  int checks;
  int errors;

  // reference model state
  int m_a, m_ca, m_b, m_cb, m_adj_prev;

  mod_counter #(.WIDTH(6), .MODULUS(60)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .carry_in(carry_in), .down(down),
    .hold(hold), .adj(adj), .load(load), .load_val(load_val),
    .count(count_a), .carry_out(carry_a)
  );

  // full-range instance: MODULUS = 2**WIDTH
  mod_counter #(.WIDTH(4), .MODULUS(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .carry_in(carry_in), .down(down),
    .hold(hold), .adj(adj), .load(load), .load_val(load_val[3:0]),
    .count(count_b), .carry_out(carry_b)
  );

  mod_counter #(.WIDTH(SEC_WIDTH), .MODULUS(SEC_MODULUS)) u_sec (
    .clk(clk), .rst_n(rst_n), .tick(c_tick), .carry_in(1'b1), .down(1'b0),
    .hold(HOLD_RUN), .adj(1'b0), .load(1'b0), .load_val('0),
    .count(sec_cnt), .carry_out(sec_co)
  );

  mod_counter #(.WIDTH(MIN_WIDTH), .MODULUS(MIN_MODULUS)) u_min (
    .clk(clk), .rst_n(rst_n), .tick(c_tick), .carry_in(sec_co), .down(1'b0),
    .hold(HOLD_RUN), .adj(1'b0), .load(1'b0), .load_val('0),
    .count(min_cnt), .carry_out(min_co)
  );

  mod_counter #(.WIDTH(HR_WIDTH), .MODULUS(HR_MODULUS)) u_hr (
    .clk(clk), .rst_n(rst_n), .tick(c_tick), .carry_in(min_co), .down(1'b0),
    .hold(HOLD_RUN), .adj(1'b0), .load(1'b0), .load_val('0),
    .count(hr_cnt), .carry_out(hr_co)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural next state for a modulo-m counter, from the current inputs
  task automatic model_next(input int c, input int m, input int lv,
                            output int nc, output int nco);
    nc  = c;
    nco = 0;
    if (!rst_n) begin
      nc = 0;
    end else if (hold[0]) begin
      nc = 0;
    end else if (load) begin
      nc = (lv < m) ? lv : 0;
    end else if (hold != 3'b000) begin
      if (adj && (m_adj_prev == 0))
        nc = down ? (c + m - 1) % m : (c + 1) % m;
    end else if (tick && carry_in) begin
      nc  = down ? (c + m - 1) % m : (c + 1) % m;
      nco = down ? int'(nc == m - 1) : int'(nc == 0);
    end
  endtask

  // Advance one clock and compare both instances against the model
  task automatic step();
    int na, nca, nb, ncb, np;
    model_next(m_a, 60, int'(load_val), na, nca);
    model_next(m_b, 16, int'(load_val) % 16, nb, ncb);
    np = rst_n ? int'(adj) : 0;
    @(posedge clk);
    #1;
    check("count_a", int'(count_a), na);
    check("carry_a", int'(carry_a), nca);
    check("count_b", int'(count_b), nb);
    check("carry_b", int'(carry_b), ncb);
    m_a = na; m_ca = nca; m_b = nb; m_cb = ncb; m_adj_prev = np;
  endtask

  task automatic idle();
    rst_n = 1'b1; tick = 1'b0; carry_in = 1'b1; down = 1'b0;
    hold = HOLD_RUN; adj = 1'b0; load = 1'b0; load_val = '0;
  endtask

  task automatic do_load(input int v);
    idle();
    load = 1'b1;
    load_val = 6'(v);
    step();
    idle();
  endtask

  initial begin
    int hr_pulses;
    checks = 0; errors = 0;
    m_a = 0; m_ca = 0; m_b = 0; m_cb = 0; m_adj_prev = 0;
    clk = 1'b0;
    c_tick = 1'b0;
    idle();

    // reset state
    rst_n = 1'b0;
    step();
    step();
    check("rst_count", int'(count_a), 0);
    check("rst_carry", int'(carry_a), 0);
    idle();

    // up wrap 58 -> 59 -> 0 -> 1
    do_load(58);
    check("up_load", int'(count_a), 58);
    tick = 1'b1;
    step(); check("up_59", int'(count_a), 59); check("up_59_co", int'(carry_a), 0);
    step(); check("up_0", int'(count_a), 0);   check("up_0_co", int'(carry_a), 1);
    step(); check("up_1", int'(count_a), 1);   check("up_1_co", int'(carry_a), 0);

    // down wrap 1 -> 0 -> 59
    do_load(1);
    down = 1'b1; tick = 1'b1;
    step(); check("dn_0", int'(count_a), 0);   check("dn_0_co", int'(carry_a), 0);
    step(); check("dn_59", int'(count_a), 59); check("dn_59_co", int'(carry_a), 1);
    idle();

    // adjust: load wins over hold=010, then held adj steps exactly once
    hold = HOLD_ADJ; load = 1'b1; load_val = 6'd59;
    step(); check("adj_load", int'(count_a), 59);
    load = 1'b0; adj = 1'b1; tick = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("adj_count", int'(count_a), 0);
      check("adj_carry", int'(carry_a), 0);
    end
    // entering adjust with adj already high gives no step
    idle();
    do_load(10);
    adj = 1'b1;
    step();
    hold = HOLD_ADJ;
    step(); check("adj_enter_high", int'(count_a), 10);
    step(); check("adj_enter_high2", int'(count_a), 10);
    idle();

    // priority: clear over load; out-of-range load gives 0
    do_load(30);
    load = 1'b1; load_val = 6'd45; hold = 3'b001;
    step(); check("clr_over_load", int'(count_a), 0);
    do_load(30);
    load = 1'b1; load_val = 6'd62;
    step(); check("load_oor", int'(count_a), 0);
    idle();

    // reset during a would-be wrap, then first count from 0
    do_load(59);
    tick = 1'b1; rst_n = 1'b0;
    step(); check("rst_wrap_cnt", int'(count_a), 0); check("rst_wrap_co", int'(carry_a), 0);
    rst_n = 1'b1;
    step(); check("post_rst_cnt", int'(count_a), 1); check("post_rst_co", int'(carry_a), 0);
    idle();

    // randomized run against the model
    for (int i = 0; i < 2000; i++) begin
      rst_n    = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 7) == 0)
        hold = ($urandom_range(0, 1) == 0) ? HOLD_RUN : 3'($urandom_range(0, 7));
      load     = ($urandom_range(0, 19) == 0);
      load_val = 6'($urandom_range(0, 63));
      tick     = ($urandom_range(0, 3) != 0);
      carry_in = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 15) == 0) down = ~down;
      if ($urandom_range(0, 3) == 0) adj = ~adj;
      step();
    end
    idle();

    // cascade: each stage lags its lower stage by one clk through the registered carry
    rst_n = 1'b0;
    step();
    idle();
    c_tick = 1'b1;
    hr_pulses = 0;
    for (int i = 1; i <= 86402; i++) begin
      @(posedge clk);
      #1;
      if (hr_co) hr_pulses++;
      if (i == 86400) begin
        check("casc_sec", int'(sec_cnt), 0);
        check("casc_sec_co", int'(sec_co), 1);
      end
      if (i == 86401) begin
        check("casc_min", int'(min_cnt), 0);
        check("casc_min_co", int'(min_co), 1);
      end
      if (i == 86402) begin
        check("casc_hr", int'(hr_cnt), 0);
        check("casc_hr_co", int'(hr_co), 1);
        check("casc_min_end", int'(min_cnt), 0);
      end
    end
    check("casc_hr_pulses", hr_pulses, 1);
    c_tick = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
